// File: rtl/uram_pkg.sv
// Shared constants and types for the URAM event-buffer write side.
package uram_pkg;
    localparam int COUNT_MAX     = 171;
    localparam int ADDR_BITS     = 14;
    localparam int NUM_BUFFERS   = 4;
    localparam int BUFFER_STRIDE = 4096;
    localparam int DATA_WIDTH    = 72;

    localparam int BUF_W = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;
    localparam int CNT_W = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
    localparam int OCC_W = $clog2(NUM_BUFFERS + 1);

    typedef logic [BUF_W-1:0]      buf_idx_t;
    typedef logic [ADDR_BITS-1:0]  addr_t;
    typedef logic [DATA_WIDTH-1:0] dat_t;
    typedef logic [OCC_W-1:0]      occ_t;

    typedef enum logic {ST_IDLE, ST_WRITE} state_e;

    function automatic addr_t region_base(input buf_idx_t idx);
        return addr_t'(int'(idx) * BUFFER_STRIDE);
    endfunction
endpackage

// File: rtl/uram_write_counter_if.sv
// Beat input, URAM write port and buffer-status signals of the write counter.
interface uram_write_counter_if;
    import uram_pkg::*;

    logic     begin_i;
    logic     dat_valid_i;
    dat_t     dat_i;
    logic     free_i;
    logic     wr_en_o;
    addr_t    wr_addr_o;
    dat_t     wr_dat_o;
    logic     complete_o;
    buf_idx_t complete_buf_o;
    logic     full_o;
    logic     overflow_o;
    logic     busy_o;

    modport slave (
        input  begin_i, dat_valid_i, dat_i, free_i,
        output wr_en_o, wr_addr_o, wr_dat_o, complete_o, complete_buf_o,
               full_o, overflow_o, busy_o
    );

    modport master (
        output begin_i, dat_valid_i, dat_i, free_i,
        input  wr_en_o, wr_addr_o, wr_dat_o, complete_o, complete_buf_o,
               full_o, overflow_o, busy_o
    );
endinterface

// File: rtl/uram_write_addr_gen.sv
// Beat counter + region address adder; URAM_WRITE_COUNTER_DSP_EN selects the
// DSP48E2 TWO24 SIMD form, otherwise a fabric counter and comparator.
module uram_write_addr_gen
    import uram_pkg::*;
(
    input  logic  clk_i,
    input  logic  rstn_i,
    input  logic  load,
    input  addr_t base,
    input  logic  beat,
    output addr_t addr,
    output logic  last
);

`ifdef URAM_WRITE_COUNTER_DSP_EN
    // Low lane counts up from 2^24-(COUNT_MAX-1); its carry-out lands exactly
    // when the count reaches COUNT_MAX-1. High lane carries base+count.
    localparam logic [23:0] LO_INIT = 24'(64'(1) << 24) - 24'(COUNT_MAX - 1);

    logic [23:0]          p_lo;
    logic [ADDR_BITS-1:0] p_hi;
    logic                 carry;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            p_lo  <= '0;
            p_hi  <= '0;
            carry <= 1'b0;
        end else if (load) begin
            p_lo  <= LO_INIT;
            p_hi  <= base;
            carry <= (COUNT_MAX == 1);
        end else if (beat) begin
            {carry, p_lo} <= {1'b0, p_lo} + 25'd1;
            p_hi          <= p_hi + addr_t'(1);
        end
    end

    assign addr = p_hi;
    assign last = carry;
`else
    logic [CNT_W-1:0] cnt;
    addr_t            base_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt    <= '0;
            base_q <= '0;
        end else if (load) begin
            cnt    <= '0;
            base_q <= base;
        end else if (beat) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign addr = base_q + addr_t'(cnt);
    assign last = (cnt == CNT_W'(COUNT_MAX - 1));
`endif

endmodule

// File: rtl/uram_write_counter.sv
// Write-side address generator for the URAM event ring: one event per region,
// occupancy tracked against reader frees. Optional macro URAM_WRITE_COUNTER_DSP_EN.
module uram_write_counter
    import uram_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rstn_i,
    uram_write_counter_if.slave   bus
);

    if (COUNT_MAX > BUFFER_STRIDE) begin : g_chk_stride
        $error("COUNT_MAX must not exceed BUFFER_STRIDE");
    end
    if (NUM_BUFFERS * BUFFER_STRIDE > (1 << ADDR_BITS)) begin : g_chk_span
        $error("buffer ring does not fit in ADDR_BITS");
    end

    state_e   state, state_nx;
    buf_idx_t wptr;
    occ_t     occ, occ_nx;
    logic     full_q;
    logic     beat, last, done, take_begin, drop, rel, load;
    addr_t    addr;

    uram_write_addr_gen u_addr_gen (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .load   (load),
        .base   (region_base(wptr)),
        .beat   (beat),
        .addr   (addr),
        .last   (last)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= ST_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (take_begin) state_nx = ST_WRITE;
            ST_WRITE: if (done)       state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        beat       = (state == ST_WRITE) && bus.dat_valid_i;
        done       = beat && last;
        take_begin = (state == ST_IDLE) && bus.begin_i && !full_q;
        drop       = (state == ST_IDLE) && bus.begin_i && full_q;
        load       = take_begin;
        // A free at zero occupancy has nothing to release.
        rel        = bus.free_i && (occ != '0);
        occ_nx     = occ;
        if (done && !rel)      occ_nx = occ + occ_t'(1);
        else if (!done && rel) occ_nx = occ - occ_t'(1);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bus.wr_en_o        <= 1'b0;
            bus.wr_addr_o      <= '0;
            bus.wr_dat_o       <= '0;
            bus.complete_o     <= 1'b0;
            bus.complete_buf_o <= '0;
            bus.overflow_o     <= 1'b0;
            full_q             <= 1'b0;
            wptr               <= '0;
            occ                <= '0;
        end else begin
            bus.wr_en_o    <= beat;
            bus.complete_o <= done;
            bus.overflow_o <= drop;
            if (beat) begin
                bus.wr_addr_o <= addr;
                bus.wr_dat_o  <= bus.dat_i;
            end
            if (done) begin
                bus.complete_buf_o <= wptr;
                wptr               <= (NUM_BUFFERS == 1) ? '0 : wptr + buf_idx_t'(1);
            end
            occ    <= occ_nx;
            full_q <= (occ_nx == occ_t'(NUM_BUFFERS));
        end
    end

    assign bus.full_o = full_q;
    assign bus.busy_o = (state == ST_WRITE);

endmodule

// File: tb/tb_uram_write_counter.sv
// Randomized bench for uram_write_counter against an event-level reference model.
module tb_uram_write_counter;
    localparam int CM     = 171;
    localparam int STRIDE = 4096;
    localparam int NB     = 4;

    logic clk = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk = ~clk;

    uram_write_counter_if bus();

    uram_write_counter dut (
        .clk_i  (clk),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    int nchk = 0;
    int nfail = 0;

    // reference model: event in progress, beats taken, ring pointer, occupancy
    bit m_wr;
    int m_cnt, m_wptr, m_occ;
    logic [92:0] exp_v;

    // per-run observation record
    int mism, nwr, ncomp, amin, amax;
    logic [92:0] bad_obs, bad_exp;

    function automatic logic [92:0] obs();
        return {bus.wr_en_o, bus.wr_en_o ? bus.wr_addr_o : 14'd0,
                bus.wr_en_o ? bus.wr_dat_o : 72'd0,
                bus.complete_o, bus.complete_o ? bus.complete_buf_o : 2'd0,
                bus.full_o, bus.overflow_o, bus.busy_o};
    endfunction

    task automatic model_reset();
        m_wr = 0; m_cnt = 0; m_wptr = 0; m_occ = 0; exp_v = '0;
    endtask

    task automatic model_step(input bit b, input bit dv, input logic [71:0] d, input bit fr);
        bit e_wr, e_c, e_ov, done;
        int old;
        logic [13:0] ea;
        logic [71:0] ed;
        logic [1:0]  ec;
        e_wr = 0; e_c = 0; e_ov = 0; done = 0; old = m_occ;
        ea = '0; ed = '0; ec = '0;
        if (m_wr) begin
            if (dv) begin
                e_wr = 1; ea = 14'(m_wptr * STRIDE + m_cnt); ed = d; m_cnt++;
                if (m_cnt == CM) begin
                    done = 1; e_c = 1; ec = 2'(m_wptr);
                    m_wptr = (m_wptr + 1) % NB; m_wr = 0;
                end
            end
        end else if (b) begin
            if (old == NB) e_ov = 1;
            else begin m_wr = 1; m_cnt = 0; end
        end
        m_occ = old + (done ? 1 : 0) - ((fr && old > 0) ? 1 : 0);
        exp_v = {e_wr, ea, ed, e_c, ec, (m_occ == NB), e_ov, m_wr};
    endtask

    task automatic clear_rec();
        mism = 0; nwr = 0; ncomp = 0; amin = 1 << 30; amax = -1;
        bad_obs = '0; bad_exp = '0;
    endtask

    task automatic tick(input bit b, input bit dv, input logic [71:0] d, input bit fr);
        bus.begin_i = b; bus.dat_valid_i = dv; bus.dat_i = d; bus.free_i = fr;
        model_step(b, dv, d, fr);
        @(posedge clk); #1;
        bus.begin_i = 0; bus.dat_valid_i = 0; bus.free_i = 0;
        if (obs() !== exp_v) begin
            if (mism == 0) begin bad_obs = obs(); bad_exp = exp_v; end
            mism++;
        end
        if (bus.wr_en_o === 1'b1) begin
            nwr++;
            if (int'(bus.wr_addr_o) < amin) amin = int'(bus.wr_addr_o);
            if (int'(bus.wr_addr_o) > amax) amax = int'(bus.wr_addr_o);
        end
        if (bus.complete_o === 1'b1) ncomp++;
    endtask

    task automatic run_event(input int gap_pct, input bit noise, input bit free_on_last);
        logic [95:0] r;
        bit dv, b, fr;
        clear_rec();
        tick(1, 0, '0, 0);
        for (int i = 0; i < 4000 && m_wr; i++) begin
            r  = {$urandom(), $urandom(), $urandom()};
            dv = ($urandom_range(99) >= gap_pct);
            b  = noise && ($urandom_range(9) == 0);
            fr = free_on_last && dv && (m_cnt == CM - 1);
            tick(b, dv, r[71:0], fr);
        end
    endtask

    task automatic do_reset();
        rstn_i = 0; model_reset();
        bus.begin_i = 0; bus.dat_valid_i = 0; bus.dat_i = '0; bus.free_i = 0;
        @(posedge clk); #1;
        rstn_i = 1;
    endtask

    task automatic test_reset();
        do_reset();
        nchk++;
        if ({bus.wr_en_o, bus.wr_addr_o, bus.wr_dat_o, bus.complete_o, bus.complete_buf_o,
             bus.full_o, bus.overflow_o, bus.busy_o} !== 93'd0) begin
            nfail++;
            $display("FAIL reset_outputs got=%h want=0", obs());
        end
    endtask

    task automatic test_single_event();
        run_event(0, 0, 0);
        nchk++;
        if (mism != 0) begin nfail++; $display("FAIL single_trace got=%h want=%h", bad_obs, bad_exp); end
        nchk++;
        if (nwr != CM || amin != 0 || amax != CM - 1) begin
            nfail++; $display("FAIL single_span got=%0d/%0d..%0d want=%0d/0..%0d", nwr, amin, amax, CM, CM - 1);
        end
        nchk++;
        if (ncomp != 1 || bus.busy_o !== 1'b0) begin
            nfail++; $display("FAIL single_done got=comp%0d busy%b want=comp1 busy0", ncomp, bus.busy_o);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int k = 0; k < NB; k++) begin
            run_event(0, 0, 0);
            nchk++;
            if (mism != 0 || amin != k * STRIDE || nwr != CM) begin
                nfail++; $display("FAIL fill_ev%0d got=base%0d n%0d want=base%0d n%0d", k, amin, nwr, k * STRIDE, CM);
            end
        end
        nchk++;
        if (bus.full_o !== 1'b1) begin nfail++; $display("FAIL fill_full got=%b want=1", bus.full_o); end
        clear_rec();
        tick(1, 0, '0, 0);
        nchk++;
        if (bus.overflow_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            nfail++; $display("FAIL overflow_pulse got=ov%b busy%b want=ov1 busy0", bus.overflow_o, bus.busy_o);
        end
        for (int i = 0; i < 5; i++) tick(0, 1, 72'(i), 0);
        nchk++;
        if (mism != 0 || nwr != 0) begin
            nfail++; $display("FAIL overflow_quiet got=%h writes=%0d want=%h writes=0", bad_obs, nwr, bad_exp);
        end
    endtask

    task automatic test_wrap();
        clear_rec();
        tick(0, 0, '0, 1);
        nchk++;
        if (bus.full_o !== 1'b0) begin nfail++; $display("FAIL wrap_full_clear got=%b want=0", bus.full_o); end
        run_event(0, 0, 0);
        nchk++;
        if (mism != 0 || amin != 0 || bus.full_o !== 1'b1) begin
            nfail++; $display("FAIL wrap_base got=base%0d full%b want=base0 full1", amin, bus.full_o);
        end
    endtask

    task automatic test_gaps();
        tick(0, 0, '0, 1);
        tick(0, 0, '0, 1);
        run_event(50, 1, 0);
        nchk++;
        if (mism != 0) begin nfail++; $display("FAIL gaps_trace got=%h want=%h", bad_obs, bad_exp); end
        nchk++;
        if (nwr != CM || amin != STRIDE || amax != STRIDE + CM - 1) begin
            nfail++; $display("FAIL gaps_span got=%0d/%0d..%0d want=%0d/%0d..%0d", nwr, amin, amax, CM, STRIDE, STRIDE + CM - 1);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        for (int k = 0; k < 3; k++) run_event(0, 0, 0);
        run_event(30, 0, 1);
        nchk++;
        if (mism != 0 || bus.full_o !== 1'b0) begin
            nfail++; $display("FAIL same_cycle got=full%b want=full0", bus.full_o);
        end
        run_event(0, 0, 0);
        nchk++;
        if (bus.full_o !== 1'b1) begin nfail++; $display("FAIL same_cycle_occ3 got=%b want=1", bus.full_o); end
        clear_rec();
        for (int i = 0; i < NB + 2; i++) tick(0, 0, '0, 1);
        for (int k = 0; k < NB; k++) run_event(0, 0, 0);
        nchk++;
        if (mism != 0 || bus.full_o !== 1'b1) begin
            nfail++; $display("FAIL free_at_zero got=full%b want=full1", bus.full_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        clear_rec();
        tick(1, 0, '0, 0);
        for (int i = 0; i < 80; i++) tick(0, 1, 72'($urandom()), 0);
        #2 rstn_i = 0;
        #1;
        nchk++;
        if (bus.wr_en_o !== 1'b0 || obs() !== 93'd0) begin
            nfail++; $display("FAIL reset_mid got=en%b %h want=en0 0", bus.wr_en_o, obs());
        end
        model_reset();
        @(posedge clk); #1;
        rstn_i = 1;
        run_event(20, 0, 0);
        nchk++;
        if (mism != 0 || amin != 0 || nwr != CM) begin
            nfail++; $display("FAIL reset_mid_restart got=base%0d n%0d want=base0 n%0d", amin, nwr, CM);
        end
    endtask

    initial begin
        bus.begin_i = 0; bus.dat_valid_i = 0; bus.dat_i = '0; bus.free_i = 0;
        model_reset();
        test_reset();
        test_single_event();
        test_fill_overflow();
        test_wrap();
        test_gaps();
        test_same_cycle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
